// File: rtl/alu_muldiv_seq.sv
// rtl/alu_muldiv_seq.sv - sequential ALU with iterative shift-add multiply and restoring divide
// Define ALU_MULDIV_DIV_EN to build the divider; without it the divide codes decode as illegal.
module alu_muldiv_seq #(
  parameter int WORD    = 32,
  parameter int SHAMT_W = $clog2(WORD)
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            Start_in,
  input  logic [WORD-1:0] A_in,
  input  logic [WORD-1:0] B_in,
  input  logic [4:0]      Function_select,
  output logic            Ready_out,
  output logic            Valid_out,
  output logic [WORD-1:0] Result,
  output logic            Illegal_out
);

  localparam int CW = $clog2(WORD);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t state, state_nxt;

  logic              accept;
  logic [SHAMT_W-1:0] shamt;
  logic [WORD-1:0]   base_res, imm_res;
  logic              base_ill, imm_ill, go_mul, go_div;
  logic              a_se, b_se, a_neg, b_neg;
  logic [WORD-1:0]   a_mag, b_mag;

  logic [2*WORD-1:0] p, p_step, p_fin;
  logic [WORD-1:0]   mcand, mul_out;
  logic [WORD:0]     mul_sum;
  logic              neg, hi;
  logic [CW-1:0]     cnt;
  logic              last;

  assign accept = Start_in && (state == S_IDLE);
  assign shamt  = B_in[SHAMT_W-1:0];
  assign last   = (cnt == CW'(WORD-1));

  // Base ops and the cases that finish in a single cycle
  always_comb begin
    base_res = '0;
    base_ill = 1'b0;
    case (Function_select[3:0])
      4'h0: base_res = A_in + B_in;
      4'h8: base_res = A_in - B_in;
      4'h4: base_res = A_in ^ B_in;
      4'h6: base_res = A_in | B_in;
      4'h7: base_res = A_in & B_in;
      4'h1: base_res = A_in << shamt;
      4'h5: base_res = A_in >> shamt;
      4'hC: base_res = $unsigned($signed(A_in) >>> shamt);
      4'h2: base_res = {{(WORD-1){1'b0}}, ($signed(A_in) < $signed(B_in))};
      4'h3: base_res = {{(WORD-1){1'b0}}, (A_in < B_in)};
      default: base_ill = 1'b1;
    endcase
  end

  always_comb begin
    imm_res = '0;
    imm_ill = 1'b0;
    go_mul  = 1'b0;
    go_div  = 1'b0;
    if (!Function_select[4]) begin
      imm_res = base_res;
      imm_ill = base_ill;
    end else if (Function_select[3]) begin
      imm_ill = 1'b1;
    end else if (!Function_select[2]) begin
      go_mul = 1'b1;
    end else begin
`ifdef ALU_MULDIV_DIV_EN
      if (B_in == '0)
        imm_res = Function_select[1] ? A_in : '1;
      else if (!Function_select[0] && A_in == {1'b1, {(WORD-1){1'b0}}} && B_in == '1)
        imm_res = Function_select[1] ? '0 : A_in;
      else
        go_div = 1'b1;
`else
      imm_ill = 1'b1;
`endif
    end
  end

  // Operand signedness: divides key off bit 0, multiplies off bits [1:0]
  always_comb begin
    if (Function_select[2]) begin
      a_se = ~Function_select[0];
      b_se = ~Function_select[0];
    end else begin
      a_se = (Function_select[1:0] == 2'd1) || (Function_select[1:0] == 2'd2);
      b_se = (Function_select[1:0] == 2'd1);
    end
    a_neg = a_se & A_in[WORD-1];
    b_neg = b_se & B_in[WORD-1];
    a_mag = a_neg ? -A_in : A_in;
    b_mag = b_neg ? -B_in : B_in;
  end

  always_comb begin
    mul_sum = {1'b0, p[2*WORD-1:WORD]} + {1'b0, (p[0] ? mcand : '0)};
    p_step  = {mul_sum, p[WORD-1:1]};
    p_fin   = neg ? -p_step : p_step;
    mul_out = hi ? p_fin[2*WORD-1:WORD] : p_fin[WORD-1:0];
  end

`ifdef ALU_MULDIV_DIV_EN
  logic [WORD-1:0] quo, rem, dsr, quo_step, rem_step, div_out;
  logic [WORD:0]   shifted;
  logic            ge, qneg, rneg, want_rem;

  always_comb begin
    shifted  = {rem, quo[WORD-1]};
    ge       = shifted >= {1'b0, dsr};
    rem_step = ge ? (shifted[WORD-1:0] - dsr) : shifted[WORD-1:0];
    quo_step = {quo[WORD-2:0], ge};
    if (want_rem)
      div_out = rneg ? -rem_step : rem_step;
    else
      div_out = qneg ? -quo_step : quo_step;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      quo      <= '0;
      rem      <= '0;
      dsr      <= '0;
      qneg     <= 1'b0;
      rneg     <= 1'b0;
      want_rem <= 1'b0;
    end else if (accept && go_div) begin
      quo      <= a_mag;
      rem      <= '0;
      dsr      <= b_mag;
      qneg     <= a_neg ^ b_neg;
      rneg     <= a_neg;
      want_rem <= Function_select[1];
    end else if (state == S_DIV) begin
      quo <= quo_step;
      rem <= rem_step;
    end
  end
`endif

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept) state_nxt = go_mul ? S_MUL : (go_div ? S_DIV : S_DONE);
      S_MUL:  if (last) state_nxt = S_DONE;
`ifdef ALU_MULDIV_DIV_EN
      S_DIV:  if (last) state_nxt = S_DONE;
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    Ready_out = (state == S_IDLE);
    Valid_out = (state == S_DONE);
  end

  // Result is loaded on the edge entering DONE so it lines up with Valid_out
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      p           <= '0;
      mcand       <= '0;
      neg         <= 1'b0;
      hi          <= 1'b0;
      cnt         <= '0;
      Result      <= '0;
      Illegal_out <= 1'b0;
    end else if (accept) begin
      cnt <= '0;
      if (go_mul) begin
        p     <= {{WORD{1'b0}}, b_mag};
        mcand <= a_mag;
        neg   <= a_neg ^ b_neg;
        hi    <= (Function_select[1:0] != 2'd0);
      end else if (!go_div) begin
        Result      <= imm_res;
        Illegal_out <= imm_ill;
      end
    end else if (state == S_MUL) begin
      p   <= p_step;
      cnt <= cnt + CW'(1);
      if (last) begin
        Result      <= mul_out;
        Illegal_out <= 1'b0;
      end
    end
`ifdef ALU_MULDIV_DIV_EN
    else if (state == S_DIV) begin
      cnt <= cnt + CW'(1);
      if (last) begin
        Result      <= div_out;
        Illegal_out <= 1'b0;
      end
    end
`endif
  end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// tb/tb_alu_muldiv_seq.sv - directed-vector bench for alu_muldiv_seq at WORD=32
module tb_alu_muldiv_seq;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Start_in;
  logic [31:0] A_in, B_in;
  logic [4:0]  Function_select;
  logic        Ready_out, Valid_out, Illegal_out;
  logic [31:0] Result;

  int checks = 0;
  int failures = 0;

  alu_muldiv_seq #(.WORD(32)) dut (
    .Clk(Clk), .Reset(Reset), .Start_in(Start_in), .A_in(A_in), .B_in(B_in),
    .Function_select(Function_select), .Ready_out(Ready_out), .Valid_out(Valid_out),
    .Result(Result), .Illegal_out(Illegal_out)
  );

  always #5 Clk = ~Clk;

  // Accepts one op, scrambles operands afterwards, and waits a bounded time for Valid_out
  task automatic do_op(input logic [4:0] f, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] r, output logic il, output int lat, output bit rdy_hi);
    @(negedge Clk);
    Function_select = f; A_in = a; B_in = b; Start_in = 1'b1;
    @(posedge Clk);
    #1;
    Start_in = 1'b0; A_in = $urandom; B_in = $urandom; Function_select = 5'h1F;
    lat = -1; rdy_hi = 1'b0; r = 'x; il = 1'bx;
    for (int i = 1; i <= 100; i++) begin
      @(negedge Clk);
      if (Valid_out) begin
        lat = i; r = Result; il = Illegal_out;
        break;
      end
      if (Ready_out) rdy_hi = 1'b1;
    end
  endtask

  task automatic test_reset;
    Reset = 1'b1; Start_in = 1'b0; A_in = '0; B_in = '0; Function_select = '0;
    #3;
    checks++;
    if ({Ready_out, Valid_out, Illegal_out} !== 3'b100 || Result !== 32'h0) begin
      failures++;
      $display("FAIL reset: rdy/vld/ill=%b result=%h required 100 / 00000000",
               {Ready_out, Valid_out, Illegal_out}, Result);
    end
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
  endtask

  task automatic test_base;
    logic [4:0]  tf [10];
    logic [31:0] ta [10], tb [10], te [10];
    logic [31:0] r; logic il; int lat; bit rh;
    tf = '{5'h08, 5'h00, 5'h04, 5'h06, 5'h07, 5'h01, 5'h05, 5'h0C, 5'h02, 5'h03};
    ta = '{32'd5, 32'hFFFFFFFF, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'hF0F0F0F0,
           32'd1, 32'h80000000, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
    tb = '{32'd7, 32'd1, 32'hFF00FF00, 32'h0F0F0000, 32'hFF00FF00,
           32'h21, 32'h3F, 32'h24, 32'd1, 32'd1};
    te = '{32'hFFFFFFFE, 32'h0, 32'h0FF00FF0, 32'hFFFFF0F0, 32'hF000F000,
           32'd2, 32'd1, 32'hF8000000, 32'd1, 32'd0};
    for (int i = 0; i < 10; i++) begin
      do_op(tf[i], ta[i], tb[i], r, il, lat, rh);
      checks++;
      if (r !== te[i] || il !== 1'b0 || lat != 1) begin
        failures++;
        $display("FAIL base op %h: result=%h ill=%b lat=%0d required %h 0 1", tf[i], r, il, lat, te[i]);
      end
    end
  endtask

  task automatic test_illegal;
    logic [4:0] tf [4];
    logic [31:0] r; logic il; int lat; bit rh;
    tf = '{5'h09, 5'h18, 5'h0F, 5'h1F};
    for (int i = 0; i < 4; i++) begin
      do_op(tf[i], 32'h1234, 32'h5678, r, il, lat, rh);
      checks++;
      if (r !== 32'h0 || il !== 1'b1 || lat != 1) begin
        failures++;
        $display("FAIL illegal %h: result=%h ill=%b lat=%0d required 00000000 1 1", tf[i], r, il, lat);
      end
    end
  endtask

  task automatic test_mul;
    logic [4:0]  tf [6];
    logic [31:0] ta [6], tb [6], te [6];
    logic [31:0] r; logic il; int lat; bit rh;
    tf = '{5'h10, 5'h11, 5'h12, 5'h11, 5'h13, 5'h13};
    ta = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'h12345678, 32'hFFFFFFFF};
    tb = '{32'd5, 32'hFFFFFFFF, 32'd2, 32'h80000000, 32'h10, 32'hFFFFFFFF};
    te = '{32'hFFFFFFF1, 32'h0, 32'hFFFFFFFF, 32'h40000000, 32'h1, 32'hFFFFFFFE};
    for (int i = 0; i < 6; i++) begin
      do_op(tf[i], ta[i], tb[i], r, il, lat, rh);
      checks++;
      if (r !== te[i] || il !== 1'b0 || lat != 33 || rh) begin
        failures++;
        $display("FAIL mul op %h: result=%h ill=%b lat=%0d ready_seen=%b required %h 0 33 0",
                 tf[i], r, il, lat, rh, te[i]);
      end
    end
  endtask

  task automatic test_div;
    logic [4:0]  tf [10];
    logic [31:0] ta [10], tb [10], te [10];
    int          tl [10];
    logic [31:0] r; logic il; int lat; bit rh;
    tf = '{5'h14, 5'h16, 5'h15, 5'h17, 5'h14, 5'h16, 5'h15, 5'h17, 5'h14, 5'h16};
    ta = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd9, 32'd9, 32'h80000000, 32'h80000000,
           32'd100, 32'd100, 32'd7, 32'd7};
    tb = '{32'd2, 32'd2, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF,
           32'd7, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFE};
`ifdef ALU_MULDIV_DIV_EN
    te = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd9, 32'h80000000, 32'h0,
           32'd14, 32'd2, 32'hFFFFFFFD, 32'd1};
    tl = '{33, 33, 1, 1, 1, 1, 33, 33, 33, 33};
    for (int i = 0; i < 10; i++) begin
      do_op(tf[i], ta[i], tb[i], r, il, lat, rh);
      checks++;
      if (r !== te[i] || il !== 1'b0 || lat != tl[i]) begin
        failures++;
        $display("FAIL div op %h: result=%h ill=%b lat=%0d required %h 0 %0d",
                 tf[i], r, il, lat, te[i], tl[i]);
      end
    end
`else
    te = '{10{32'h0}};
    tl = '{10{1}};
    for (int i = 0; i < 4; i++) begin
      do_op(tf[i], ta[i], tb[i], r, il, lat, rh);
      checks++;
      if (r !== te[i] || il !== 1'b1 || lat != tl[i]) begin
        failures++;
        $display("FAIL div code %h without divider: result=%h ill=%b lat=%0d required 00000000 1 1",
                 tf[i], r, il, lat);
      end
    end
`endif
  endtask

  task automatic test_abort;
    bit vseen = 1'b0;
    bit rbusy = 1'b0;
    @(negedge Clk);
    Function_select = 5'h11; A_in = 32'd3; B_in = 32'd5; Start_in = 1'b1;
    @(posedge Clk);
    #1 Start_in = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge Clk);
      if (Valid_out) vseen = 1'b1;
      if (Ready_out) rbusy = 1'b1;
      if (c == 10) begin
        Function_select = 5'h00; A_in = 32'd1; B_in = 32'd1; Start_in = 1'b1;
      end else begin
        Start_in = 1'b0;
      end
    end
    checks++;
    if (vseen || rbusy) begin
      failures++;
      $display("FAIL busy during mul: valid_seen=%b ready_seen=%b required 0 0", vseen, rbusy);
    end
    Reset = 1'b1;
    #1;
    checks++;
    if ({Ready_out, Valid_out, Illegal_out} !== 3'b100 || Result !== 32'h0) begin
      failures++;
      $display("FAIL async reset: rdy/vld/ill=%b result=%h required 100 / 00000000",
               {Ready_out, Valid_out, Illegal_out}, Result);
    end
    vseen = 1'b0; rbusy = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge Clk);
      if (Valid_out) vseen = 1'b1;
      if (!Ready_out) rbusy = 1'b1;
      if (c == 3) Reset = 1'b0;
    end
    checks++;
    if (vseen || rbusy) begin
      failures++;
      $display("FAIL abandoned op: valid_seen=%b not_ready_seen=%b required 0 0", vseen, rbusy);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] r; logic il; int lat; bit rh;
    do_op(5'h00, 32'd2, 32'd3, r, il, lat, rh);
    checks++;
    if (r !== 32'd5 || il !== 1'b0 || lat != 1) begin
      failures++;
      $display("FAIL b2b add: result=%h ill=%b lat=%0d required 00000005 0 1", r, il, lat);
    end
    do_op(5'h10, 32'd6, 32'd7, r, il, lat, rh);
    checks++;
    if (r !== 32'd42 || il !== 1'b0 || lat != 33) begin
      failures++;
      $display("FAIL b2b mul: result=%h ill=%b lat=%0d required 0000002a 0 33", r, il, lat);
    end
    do_op(5'h0A, 32'd6, 32'd7, r, il, lat, rh);
    checks++;
    if (r !== 32'd0 || il !== 1'b1 || lat != 1) begin
      failures++;
      $display("FAIL b2b illegal: result=%h ill=%b lat=%0d required 00000000 1 1", r, il, lat);
    end
  endtask

  initial begin
    test_reset();
    test_base();
    test_illegal();
    test_mul();
    test_div();
    test_abort();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
